// File: rtl/mine_count_builder.sv
// Neighbour-count map builder for the mine grid.
// Walks cells in raster order, reads 9 slots per cell, writes one 4-bit code.
module mine_count_builder #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mine_rd_addr,
  input  logic              mine_rd_data,
  output logic [ADDR_W-1:0] cnt_wr_addr,
  output logic [3:0]        cnt_wr_data,
  output logic              cnt_wr_en,
  output logic              busy,
  output logic              done,
  output logic [8:0]        mine_total
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = ADDR_W - COL_W;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [1:0] DR_LAST = 2'(RD_LAT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [3:0]        slot;
  logic [1:0]        dcnt;
  logic [3:0]        acc;
  logic              self_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] vtag;
  logic [RD_LAT-1:0] stag;

  logic             up, dn, lf, rt;
  logic             inb;
  logic [ROW_W-1:0] nrow;
  logic [COL_W-1:0] ncol;
  logic             last_cell;
  logic             rd_slot;

  // Slot order: SELF, NW, N, NE, W, E, SW, S, SE
  always_comb begin
    up = 1'b0;
    dn = 1'b0;
    lf = 1'b0;
    rt = 1'b0;
    unique case (slot)
      4'd1:    begin up = 1'b1; lf = 1'b1; end
      4'd2:    up = 1'b1;
      4'd3:    begin up = 1'b1; rt = 1'b1; end
      4'd4:    lf = 1'b1;
      4'd5:    rt = 1'b1;
      4'd6:    begin dn = 1'b1; lf = 1'b1; end
      4'd7:    dn = 1'b1;
      4'd8:    begin dn = 1'b1; rt = 1'b1; end
      default: ;
    endcase
  end

  assign inb = !(up && row == '0) && !(dn && row == ROW_MAX)
            && !(lf && col == '0) && !(rt && col == COL_MAX);
  assign nrow = up ? row - 1'b1 : (dn ? row + 1'b1 : row);
  assign ncol = lf ? col - 1'b1 : (rt ? col + 1'b1 : col);
  assign rd_slot = (state == S_READ) && inb;
  assign last_cell = (row == ROW_MAX) && (col == COL_MAX);

  assign mine_rd_addr = rd_slot ? {nrow, ncol} : addr_q;
  assign cnt_wr_addr  = {row, col};
  assign cnt_wr_data  = self_q ? 4'd9 : acc;
  assign cnt_wr_en    = (state == S_WRITE);
  assign busy = (state == S_READ) || (state == S_DRAIN)
             || (state == S_WRITE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      slot       <= '0;
      dcnt       <= '0;
      acc        <= '0;
      self_q     <= 1'b0;
      addr_q     <= '0;
      vtag       <= '0;
      stag       <= '0;
      mine_total <= '0;
    end else begin
      vtag[0] <= rd_slot;
      stag[0] <= (slot == 4'd0);
      for (int i = 1; i < RD_LAT; i++) begin
        vtag[i] <= vtag[i-1];
        stag[i] <= stag[i-1];
      end
      if (vtag[RD_LAT-1]) begin
        if (stag[RD_LAT-1])
          self_q <= mine_rd_data;
        else if (mine_rd_data)
          acc <= acc + 4'd1;
      end
      if (rd_slot)
        addr_q <= {nrow, ncol};
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_READ;
            row        <= '0;
            col        <= '0;
            slot       <= '0;
            acc        <= '0;
            self_q     <= 1'b0;
            mine_total <= '0;
          end
        end
        S_READ: begin
          if (slot == 4'd8) begin
            state <= S_DRAIN;
            dcnt  <= '0;
          end else begin
            slot <= slot + 4'd1;
          end
        end
        S_DRAIN: begin
          if (dcnt == DR_LAST)
            state <= S_WRITE;
          else
            dcnt <= dcnt + 2'd1;
        end
        S_WRITE: begin
          if (self_q && mine_total != 9'd511)
            mine_total <= mine_total + 9'd1;
          if (col == COL_MAX) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          slot   <= '0;
          acc    <= '0;
          self_q <= 1'b0;
          state  <= last_cell ? S_DONE : S_READ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
